lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//   Load/store unit sitting between the RV32I execute stage and data_mem. Accepts one
//   load/store per handshake and drives data_mem's word address, byte mask, replicated
//   write data and write strobe. Extracts and sign/zero-extends load data.
//   Flags misaligned or illegal accesses and never writes memory for them.
// PARAMETERS
//   ADDR_W  12  width of mem_addr (word index = req_addr[ADDR_W+1:2])
// PORTS
//   clk           in   1       single clock, rising edge
//   rst           in   1       synchronous, active-high reset
//   req_valid     in   1       core presents a request
//   req_ready     out  1       LSU can accept (high only in IDLE)
//   req_we        in   1       1 = store, 0 = load
//   req_funct3    in   3       RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr      in   32      byte address
//   req_wdata     in   32      store data (rs2)
//   mem_addr      out  ADDR_W  word address to data_mem
//   mem_wdata     out  32      lane-replicated write data
//   mem_wr        out  1       write strobe, one-cycle pulse
//   mem_mask      out  4       byte-lane enables, bit i = byte i
//   mem_rdata     in   32      data_mem combinational read data
//   rsp_valid     out  1       one-cycle response pulse
//   rsp_rdata     out  32      extended load result (0 for stores and errors)
//   rsp_err       out  1       misaligned or illegal funct3
// BEHAVIOUR
// - Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0;
//   mem_wr=0; mem_mask=0; mem_addr=0; mem_wdata=0.
// - FSM IDLE -> ACCESS -> RESP -> IDLE. Transitions are unconditional except IDLE.
//   IDLE leaves only on req_valid (req_ready=1 there). Accept edge T; ACCESS at T+1;
//   rsp_valid at T+2. Max throughput is one request per 3 cycles.
// - Accept registers we, funct3, addr, wdata and err. off = addr[1:0].
// - Mask/data: SB: mask = 4'b0001<<off, wdata = {4{wd[7:0]}}.
//   SH: mask = 4'b0011<<off, wdata = {2{wd[15:0]}}. SW: mask = 4'hF, wdata = wd.
//   Loads drive mask = 0.
// - err = (half && off[0]) | (word && off!=0) | illegal funct3.
//   Illegal loads: 011, 110, 111. Illegal stores: anything but 000/001/010.
// - ACCESS: mem_addr/mem_mask/mem_wdata valid. mem_wr = we & !err & !rst.
//   Load data is sampled from mem_rdata into rsp_rdata at the end of ACCESS.
// - Load extract: byte = rdata[8*off+:8], half = rdata[16*off[1]+:16].
//   LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
// - RESP: rsp_valid=1 for exactly one cycle; rsp_err is valid alongside it.
//   There is no response backpressure.
// - mem_* outputs are 0 outside ACCESS.
// - rst in any state -> IDLE next edge. rst during ACCESS suppresses mem_wr that cycle.
//   rst during RESP: the pulse already visible is kept; no further response follows.
// - req_valid while not in IDLE is ignored (req_ready=0); it is not queued.
// STRUCTURE
// - lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU), state enum lsu_state_t {IDLE,ACCESS,RESP}.
// - Sub-module lsu_load_align: combinational (rdata, off, funct3) -> 32-bit result.
//   Store lane generation and the FSM stay in lsu_ctrl.
// TESTING
// 1. SB addr=0x103 wdata=0x12AB -> at T+1 mem_addr=0x40, mask=4'b1000,
//    mem_wdata=0xABABABAB, mem_wr=1; T+2 rsp_valid=1, rsp_err=0.
// 2. LH addr=0x2, mem_rdata=0x8001_5555 -> rsp_rdata=0xFFFF8001.
//    LHU same -> 0x00008001. LB addr=0x1 -> 0x00000055.
// 3. SW addr=0x6 -> mem_wr stays 0 throughout; T+2 rsp_valid=1, rsp_err=1, rsp_rdata=0.
//    funct3=3'b011 load -> rsp_err=1.
// 4. req_valid held high for 9 cycles with 3 distinct SWs -> exactly 3 accepts,
//    3 mem_wr pulses, req_ready low 2 of every 3 cycles.
// 5. rst asserted in the ACCESS cycle of an SW -> no mem_wr pulse, no rsp_valid,
//    IDLE with req_ready=1 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// and the access-legality check applied when a request is accepted.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_t;

   // Half/word are decoded from funct3[1:0] so LHU shares the LH alignment rule.
   function automatic logic access_err(input logic we, input logic [2:0] f3,
                                       input logic [1:0] off);
      logic illegal;
      logic half;
      logic word;
      if (we) illegal = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
      else    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      half = (f3[1:0] == 2'b01);
      word = (f3[1:0] == 2'b10);
      return illegal | (half & off[0]) | (word & (off != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction: selects the addressed byte/half of the read word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[8*off +: 8];
      half_v = rdata[16*off[1] +: 16];
      result = rdata;
      case (funct3)
         F3_B:    result = {{24{byte_v[7]}}, byte_v};
         F3_H:    result = {{16{half_v[15]}}, half_v};
         F3_BU:   result = {24'd0, byte_v};
         F3_HU:   result = {16'd0, half_v};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit control: one request per IDLE->ACCESS->RESP pass, drives data_mem
// lanes during ACCESS and returns an extended load result or error in RESP.
//
// state  | meaning
// IDLE   | req_ready high, waiting for req_valid
// ACCESS | mem_* driven, load data captured at end of cycle
// RESP   | one-cycle rsp_valid with rsp_err / rsp_rdata
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_wr,
   output logic [3:0]        mem_mask,
   input  logic [31:0]       mem_rdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   lsu_state_t        state_q, state_d;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              err_q;
   logic [31:0]       rdata_q;
   logic [31:0]       load_res;
   logic              accept;

   // Upper address bits lie outside data_mem and are intentionally dropped.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   assign accept = (state_q == IDLE) && req_valid;

   lsu_load_align u_align (
      .rdata  (mem_rdata),
      .off    (addr_q[1:0]),
      .funct3 (f3_q),
      .result (load_res)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
            err_q   <= access_err(req_we, req_funct3, req_addr[1:0]);
         end
         if (state_q == ACCESS)
            rdata_q <= (!we_q && !err_q) ? load_res : 32'd0;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      mem_addr  = '0;
      mem_wdata = 32'd0;
      mem_wr    = 1'b0;
      mem_mask  = 4'd0;
      rsp_valid = 1'b0;
      rsp_rdata = 32'd0;
      rsp_err   = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = ACCESS;
         end
         ACCESS: begin
            state_d  = RESP;
            mem_addr = addr_q[ADDR_W+1:2];
            mem_wr   = we_q & ~err_q & ~rst;
            case (f3_q)
               F3_B: begin
                  mem_wdata = {4{wdata_q[7:0]}};
                  mem_mask  = we_q ? (4'b0001 << addr_q[1:0]) : 4'd0;
               end
               F3_H: begin
                  mem_wdata = {2{wdata_q[15:0]}};
                  mem_mask  = we_q ? (4'b0011 << addr_q[1:0]) : 4'd0;
               end
               default: begin
                  mem_wdata = wdata_q;
                  mem_mask  = we_q ? 4'hF : 4'd0;
               end
            endcase
         end
         RESP: begin
            state_d   = IDLE;
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_rdata = rdata_q;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
